// File: rtl/priority_decoder_display.sv
// rtl/priority_decoder_display.sv - registered 2-to-4 one-hot decoder with hold timer and error blink
// Define PRIO_DEC_SYNC_EN to put 2-flop synchronizers on BTN, SW and V.
module priority_decoder_display #(
  parameter int unsigned BLINK_DIV   = 25_000_000,
  parameter int unsigned HOLD_CYCLES = 100_000_000,
  parameter int unsigned CNT_W       = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] SW,
  input  logic       V,
  input  logic       BTN,
  output logic [3:0] LED,
  output logic       active,
  output logic       err
);

  typedef enum logic [1:0] {ST_IDLE, ST_SHOW, ST_ERR} state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST  = (HOLD_CYCLES > 0) ? CNT_W'(HOLD_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_DIV - 1);

  logic [1:0] w_sw;
  logic       w_v;
  logic       w_btn;
  logic       w_warm;
  logic       w_load;

`ifdef PRIO_DEC_SYNC_EN
  logic [3:0] r_sync1;
  logic [3:0] r_sync2;
  logic [1:0] r_warm;

  // r_warm marks when r_sync2 holds real samples rather than reset zeros
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_warm  <= '0;
    end else begin
      r_sync1 <= {BTN, V, SW};
      r_sync2 <= r_sync1;
      r_warm  <= {r_warm[0], 1'b1};
    end
  end

  assign w_btn  = r_sync2[3];
  assign w_v    = r_sync2[2];
  assign w_sw   = r_sync2[1:0];
  assign w_warm = r_warm[1];
`else
  assign w_btn  = BTN;
  assign w_v    = V;
  assign w_sw   = SW;
  assign w_warm = 1'b1;
`endif

  // Cleared by reset so a button already held through reset never fires
  logic r_btn_low;

  always_ff @(posedge clk) begin
    if (rst) r_btn_low <= 1'b0;
    else     r_btn_low <= ~w_btn & w_warm;
  end

  assign w_load = w_btn & r_btn_low;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_led;
  logic             r_active;
  logic             r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_led    <= 4'b0000;
      r_active <= 1'b0;
      r_err    <= 1'b0;
    end else if (w_load) begin
      r_cnt    <= '0;
      r_active <= 1'b1;
      if (w_v) begin
        r_state <= ST_SHOW;
        r_led   <= 4'b0001 << w_sw;
        r_err   <= 1'b0;
      end else begin
        r_state <= ST_ERR;
        r_led   <= 4'b1111;
        r_err   <= 1'b1;
      end
    end else begin
      case (r_state)
        ST_IDLE: ;
        ST_SHOW: begin
          if (HOLD_CYCLES != 0) begin
            if (r_cnt == HOLD_LAST) begin
              r_state  <= ST_IDLE;
              r_cnt    <= '0;
              r_led    <= 4'b0000;
              r_active <= 1'b0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        ST_ERR: begin
          if (r_cnt == BLINK_LAST) begin
            r_cnt <= '0;
            r_led <= ~r_led;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_cnt    <= '0;
          r_led    <= 4'b0000;
          r_active <= 1'b0;
          r_err    <= 1'b0;
        end
      endcase
    end
  end

  assign LED    = r_led;
  assign active = r_active;
  assign err    = r_err;

endmodule
